// File: rtl/muldiv_unit_pkg.sv
// Shared constants, encodings and operand-signedness helpers for the RV32M execute unit.
package muldiv_unit_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
   localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } md_state_e;

   function automatic logic op_signed_a(input logic [2:0] f3);
      return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
   endfunction

   function automatic logic op_signed_b(input logic [2:0] f3);
      return f3[2] ? ~f3[0] : ~f3[1];
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage operand/result bundle between the pipeline and the M-extension unit.
interface muldiv_unit_if #(
   parameter int XLEN = muldiv_unit_pkg::XLEN_DEF
);
   logic            flush_i;
   logic [6:0]      opcode_i;
   logic [2:0]      func3_i;
   logic [6:0]      func7_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            stall_o;
   logic            result_valid_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output flush_i, opcode_i, func3_i, func7_i, rs1_i, rs2_i,
      input  stall_o, result_valid_o, result_o
   );

   modport slave (
      input  flush_i, opcode_i, func3_i, func7_i, rs1_i, rs2_i,
      output stall_o, result_valid_o, result_o
   );
endinterface

// File: rtl/muldiv_unit_div_core.sv
// Unsigned radix-2 restoring divider datapath; one quotient bit per step.
module muldiv_unit_div_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o
);

   logic [XLEN-1:0] quo_q, rem_q, dvs_q;
   logic [XLEN:0]   shifted;
   logic            fits;
   logic [XLEN-1:0] rem_sub;

   // Partial remainder stays below the divisor, so the low XLEN bits of the difference suffice.
   assign shifted = {rem_q, quo_q[XLEN-1]};
   assign fits    = (shifted >= {1'b0, dvs_q});
   assign rem_sub = shifted[XLEN-1:0] - dvs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else if (load_i) begin
         quo_q <= dividend_i;
         rem_q <= '0;
         dvs_q <= divisor_i;
      end else if (step_i) begin
         quo_q <= {quo_q[XLEN-2:0], fits};
         rem_q <= fits ? rem_sub : shifted[XLEN-1:0];
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: 2-cycle multiply, XLEN+2-cycle iterative divide, pipeline stall while busy.
//   state   | meaning
//   IDLE    | waiting for an M-extension R-type op
//   MUL     | product (or divide special-case result) registered this cycle
//   DIV     | XLEN restoring steps, then sign fix-up
//   DONE    | result_valid_o for one cycle
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input logic         clk,
   input logic         rst_n,
   muldiv_unit_if.slave md
);

   localparam int CW = $clog2(XLEN) + 1;

   md_state_e         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]        f3_q, f3_d;
   logic              sa_q, sa_d, sb_q, sb_d, spec_q, spec_d;

   logic              start, accept, neg_a, neg_b, div_zero, div_ovf;
   logic              div_load, div_step;
   logic [XLEN-1:0]   abs_a, abs_b, quo, rem, div_res, spec_res;
   logic [2*XLEN-1:0] prod;

   assign start    = (md.opcode_i == OPCODE_RTYPE) && (md.func7_i == FUNC7_MULDIV);
   assign accept   = (state_q == ST_IDLE) && start && !md.flush_i;
   assign neg_a    = op_signed_a(md.func3_i) && md.rs1_i[XLEN-1];
   assign neg_b    = op_signed_b(md.func3_i) && md.rs2_i[XLEN-1];
   assign abs_a    = neg_a ? -md.rs1_i : md.rs1_i;
   assign abs_b    = neg_b ? -md.rs2_i : md.rs2_i;
   assign div_zero = (md.rs2_i == '0);
   assign div_ovf  = !md.func3_i[0] && (md.rs1_i == {1'b1, {(XLEN-1){1'b0}}})
                     && (md.rs2_i == '1);
   assign spec_res = div_zero ? (md.func3_i[1] ? md.rs1_i : '1)
                              : (md.func3_i[1] ? '0 : md.rs1_i);

   // neg flags double as sign-extension bits: zero for unsigned operands.
   assign prod    = {{XLEN{sa_q}}, a_q} * {{XLEN{sb_q}}, b_q};
   assign div_res = f3_q[1] ? (sa_q ? -rem : rem) : ((sa_q ^ sb_q) ? -quo : quo);

   muldiv_unit_div_core #(.XLEN(XLEN)) u_div_core (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (div_load),
      .step_i      (div_step),
      .dividend_i  (abs_a),
      .divisor_i   (abs_b),
      .quotient_o  (quo),
      .remainder_o (rem)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         f3_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         spec_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         f3_q    <= f3_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         spec_q  <= spec_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      f3_d     = f3_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      spec_d   = spec_q;
      div_load = 1'b0;
      div_step = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d    = md.rs1_i;
               b_d    = md.rs2_i;
               f3_d   = md.func3_i;
               sa_d   = neg_a;
               sb_d   = neg_b;
               spec_d = 1'b0;
               cnt_d  = '0;
               state_d = ST_MUL;
               if (md.func3_i[2]) begin
                  // Divide special cases reuse the one-cycle MUL slot, carrying the answer in a_q.
                  if (div_zero || div_ovf) begin
                     spec_d = 1'b1;
                     a_d    = spec_res;
                  end else begin
                     div_load = 1'b1;
                     state_d  = ST_DIV;
                  end
               end
            end
         end
         ST_MUL: begin
            if (spec_q)
               res_d = a_q;
            else if (f3_q == MD_MUL)
               res_d = prod[XLEN-1:0];
            else
               res_d = prod[2*XLEN-1:XLEN];
            state_d = ST_DONE;
         end
         ST_DIV: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN)) begin
               res_d   = div_res;
               state_d = ST_DONE;
            end else begin
               div_step = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (md.flush_i) begin
         state_d  = ST_IDLE;
         res_d    = res_q;
         div_load = 1'b0;
         div_step = 1'b0;
      end
   end

   assign md.stall_o        = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
   assign md.result_valid_o = (state_q == ST_DONE);
   assign md.result_o       = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: spec vectors, random ops vs a behavioural model, flush/reset aborts.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   muldiv_unit_if #(.XLEN(32)) md_if ();

   muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .md    (md_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint             sa, sb, ub, p;
      logic [63:0]        pu;
      logic signed [31:0] a32, b32, r32;
      logic               ovf;
      sa  = $signed(a);
      sb  = $signed(b);
      ub  = {32'b0, b};
      a32 = a;
      b32 = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r32 = '0;
      case (f3)
         3'b000: begin p = sa * sb; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            r32 = a32 / b32;
            return r32;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            r32 = a32 % b32;
            return r32;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return 2;
      if (b == 0) return 2;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 34;
   endfunction

   task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      md_if.opcode_i = OPCODE_RTYPE;
      md_if.func7_i  = FUNC7_MULDIV;
      md_if.func3_i  = f3;
      md_if.rs1_i    = a;
      md_if.rs2_i    = b;
   endtask

   task automatic go_idle();
      md_if.opcode_i = 7'b0;
      md_if.func7_i  = 7'b0;
      md_if.func3_i  = 3'b0;
   endtask

   task automatic wait_valid(input int lat0, output int lat, output int sc,
                             output logic [31:0] res, output logic sv, output bit ok);
      lat = lat0;
      sc  = 0;
      res = '0;
      sv  = 1'b0;
      ok  = 1'b0;
      while (!ok && lat < lat0 + 60) begin
         @(negedge clk);
         if (md_if.result_valid_o) begin
            ok  = 1'b1;
            res = md_if.result_o;
            sv  = md_if.stall_o;
         end else begin
            if (md_if.stall_o) sc++;
            lat++;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks += 3;
      if (md_if.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", md_if.stall_o); end
      if (md_if.result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", md_if.result_valid_o); end
      if (md_if.result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", md_if.result_o); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks += 2;
      if (md_if.stall_o !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %b want 0", md_if.stall_o); end
      if (md_if.result_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", md_if.result_valid_o); end
   endtask

   task automatic test_vectors();
      logic [2:0]  f3 [13];
      logic [31:0] a [13], b [13], e [13];
      logic [31:0] res, exp;
      logic        sv;
      bit          ok;
      int          lat, sc, l0, el;
      f3[0]  = MD_MUL;    a[0]  = 7;            b[0]  = -3;           e[0]  = 32'hFFFF_FFEB;
      f3[1]  = MD_MULHU;  a[1]  = 32'hFFFF_FFFF; b[1]  = 32'hFFFF_FFFF; e[1]  = 32'hFFFF_FFFE;
      f3[2]  = MD_MULH;   a[2]  = 32'h8000_0000; b[2]  = 32'h8000_0000; e[2]  = 32'h4000_0000;
      f3[3]  = MD_MULHSU; a[3]  = 32'hFFFF_FFFF; b[3]  = 32'hFFFF_FFFF; e[3]  = 32'hFFFF_FFFF;
      f3[4]  = MD_DIV;    a[4]  = -20;          b[4]  = 6;            e[4]  = 32'hFFFF_FFFD;
      f3[5]  = MD_REM;    a[5]  = -20;          b[5]  = 6;            e[5]  = 32'hFFFF_FFFE;
      f3[6]  = MD_DIVU;   a[6]  = 100;          b[6]  = 7;            e[6]  = 14;
      f3[7]  = MD_REMU;   a[7]  = 32'hFFFF_FFFF; b[7]  = 10;           e[7]  = 5;
      f3[8]  = MD_DIVU;   a[8]  = 100;          b[8]  = 0;            e[8]  = 32'hFFFF_FFFF;
      f3[9]  = MD_REMU;   a[9]  = 100;          b[9]  = 0;            e[9]  = 100;
      f3[10] = MD_DIV;    a[10] = 32'h8000_0000; b[10] = 32'hFFFF_FFFF; e[10] = 32'h8000_0000;
      f3[11] = MD_REM;    a[11] = 32'h8000_0000; b[11] = 32'hFFFF_FFFF; e[11] = 32'h0;
      f3[12] = MD_REM;    a[12] = 7;            b[12] = -2;           e[12] = 1;
      for (int i = 0; i < 13; i++) begin
         @(posedge clk); #1;
         drive(f3[i], a[i], b[i]);
         exp_q.push_back(e[i]);
         el = exp_lat(f3[i], a[i], b[i]);
         l0 = 0;
         if (i == 6) begin
            // operands change under a running divide, as forwarding would
            @(posedge clk); #1;
            md_if.rs1_i = $urandom;
            md_if.rs2_i = 32'h0;
            l0 = 1;
         end
         wait_valid(l0, lat, sc, res, sv, ok);
         exp = exp_q.pop_front();
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL vec[%0d] timeout: no result_valid_o within bound", i);
         end else begin
            checks += 3;
            if (res !== exp) begin errors++; $display("FAIL vec[%0d] result: got %h want %h", i, res, exp); end
            if (lat != el) begin errors++; $display("FAIL vec[%0d] latency: got %0d want %0d", i, lat, el); end
            if (sc != el - l0) begin errors++; $display("FAIL vec[%0d] stall_cycles: got %0d want %0d", i, sc, el - l0); end
            if (sv !== 1'b0) begin errors++; $display("FAIL vec[%0d] stall_in_done: got %b want 0", i, sv); end
         end
      end
      @(posedge clk); #1;
      go_idle();
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [31:0] a, b, res, exp;
      logic        sv;
      bit          ok;
      int          lat, sc, el;
      for (int i = 0; i < 16; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         @(posedge clk); #1;
         drive(f3, a, b);
         exp_q.push_back(model(f3, a, b));
         el = exp_lat(f3, a, b);
         wait_valid(0, lat, sc, res, sv, ok);
         exp = exp_q.pop_front();
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL rnd[%0d] timeout: f3=%0d a=%h b=%h", i, f3, a, b);
         end else begin
            checks += 2;
            if (res !== exp) begin errors++; $display("FAIL rnd[%0d] result f3=%0d a=%h b=%h: got %h want %h", i, f3, a, b, res, exp); end
            if (lat != el) begin errors++; $display("FAIL rnd[%0d] latency f3=%0d: got %0d want %0d", i, f3, lat, el); end
         end
      end
      @(posedge clk); #1;
      go_idle();
   endtask

   task automatic test_flush();
      logic [31:0] r0;
      bit          seen;
      r0 = md_if.result_o;
      @(posedge clk); #1;
      drive(MD_DIV, 1000, 7);
      repeat (10) @(posedge clk);
      #1;
      md_if.flush_i = 1'b1;
      @(negedge clk);
      checks++;
      if (md_if.stall_o !== 1'b1) begin errors++; $display("FAIL flush_busy_stall: got %b want 1", md_if.stall_o); end
      @(posedge clk); #1;
      md_if.flush_i = 1'b0;
      go_idle();
      @(negedge clk);
      checks += 2;
      if (md_if.stall_o !== 1'b0) begin errors++; $display("FAIL flush_after_stall: got %b want 0", md_if.stall_o); end
      if (md_if.result_valid_o !== 1'b0) begin errors++; $display("FAIL flush_after_valid: got %b want 0", md_if.result_valid_o); end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (md_if.result_valid_o) seen = 1'b1;
      end
      checks += 2;
      if (seen) begin errors++; $display("FAIL flush_no_result: result_valid_o seen 1 want never"); end
      if (md_if.result_o !== r0) begin errors++; $display("FAIL flush_result_hold: got %h want %h", md_if.result_o, r0); end
      // flush wins over a start presented in IDLE
      @(posedge clk); #1;
      drive(MD_MUL, 3, 3);
      md_if.flush_i = 1'b1;
      @(negedge clk);
      checks++;
      if (md_if.stall_o !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b want 0", md_if.stall_o); end
      @(posedge clk); #1;
      md_if.flush_i = 1'b0;
      go_idle();
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (md_if.result_valid_o) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL flush_idle_no_result: result_valid_o seen 1 want never"); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res, exp;
      logic        sv;
      bit          ok;
      int          lat, sc;
      @(posedge clk); #1;
      drive(MD_DIV, -20, 6);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      go_idle();
      #1;
      checks += 3;
      if (md_if.stall_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", md_if.stall_o); end
      if (md_if.result_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", md_if.result_valid_o); end
      if (md_if.result_o !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", md_if.result_o); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      drive(MD_MULHSU, 32'hFFFF_FFFF, 2);
      exp_q.push_back(32'hFFFF_FFFF);
      wait_valid(0, lat, sc, res, sv, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rst_mulhsu timeout: no result_valid_o within bound");
      end else begin
         checks += 2;
         if (res !== exp) begin errors++; $display("FAIL rst_mulhsu result: got %h want %h", res, exp); end
         if (lat != 2) begin errors++; $display("FAIL rst_mulhsu latency: got %0d want 2", lat); end
      end
      @(posedge clk); #1;
      go_idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] res, exp;
      logic        sv;
      bit          ok, seen;
      int          lat, sc;
      @(posedge clk); #1;
      drive(MD_DIV, 100, 7);
      exp_q.push_back(14);
      wait_valid(0, lat, sc, res, sv, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || res !== exp || lat != 34) begin
         errors++;
         $display("FAIL b2b_div: ok=%0d got %h lat %0d want %h lat 34", ok, res, lat, exp);
      end
      // next op appears while DONE is showing; it must start in the following IDLE cycle
      drive(MD_MUL, 6, 7);
      exp_q.push_back(42);
      #1;
      checks++;
      if (md_if.stall_o !== 1'b0) begin errors++; $display("FAIL b2b_done_stall: got %b want 0", md_if.stall_o); end
      wait_valid(0, lat, sc, res, sv, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || res !== exp || lat != 2) begin
         errors++;
         $display("FAIL b2b_mul: ok=%0d got %h lat %0d want %h lat 2", ok, res, lat, exp);
      end
      go_idle();
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (md_if.result_valid_o) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL b2b_extra_pulse: result_valid_o seen 1 want 0"); end
   endtask

   task automatic test_non_m();
      bit bad_stall, bad_valid;
      bad_stall = 1'b0;
      bad_valid = 1'b0;
      @(posedge clk); #1;
      md_if.opcode_i = OPCODE_RTYPE;
      md_if.func7_i  = 7'b0000000;
      md_if.func3_i  = MD_DIV;
      md_if.rs1_i    = 9;
      md_if.rs2_i    = 3;
      repeat (3) begin
         @(negedge clk);
         if (md_if.stall_o !== 1'b0) bad_stall = 1'b1;
         if (md_if.result_valid_o !== 1'b0) bad_valid = 1'b1;
      end
      @(posedge clk); #1;
      md_if.opcode_i = 7'b0010011;
      md_if.func7_i  = FUNC7_MULDIV;
      repeat (3) begin
         @(negedge clk);
         if (md_if.stall_o !== 1'b0) bad_stall = 1'b1;
         if (md_if.result_valid_o !== 1'b0) bad_valid = 1'b1;
      end
      checks += 2;
      if (bad_stall) begin errors++; $display("FAIL non_m_stall: got 1 want 0"); end
      if (bad_valid) begin errors++; $display("FAIL non_m_valid: got 1 want 0"); end
      @(posedge clk); #1;
      go_idle();
   endtask

   initial begin
      rst_n          = 1'b0;
      md_if.flush_i  = 1'b0;
      md_if.rs1_i    = '0;
      md_if.rs2_i    = '0;
      go_idle();
      test_reset();
      test_vectors();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_non_m();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
